// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  cpu_ctrl_pkg
//  Opcode/ALU codes, IR field positions and state encoding for the sequencer.
//  Revision: 1.0
// ============================================================================
package cpu_ctrl_pkg;

    localparam int OPCODE_W  = 5;
    localparam int ALUOP_W   = 4;

    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_SHRA = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_ROL  = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'd9;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'd10;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 5'd11;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'd12;

    // Code 0 selects the PC-increment path used during fetch.
    localparam logic [ALUOP_W-1:0] ALU_PCINC = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SHR   = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SHRA  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SHL   = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_ROR   = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_ROL   = 4'd9;
    localparam logic [ALUOP_W-1:0] ALU_MUL   = 4'd10;
    localparam logic [ALUOP_W-1:0] ALU_DIV   = 4'd11;
    localparam logic [ALUOP_W-1:0] ALU_NEG   = 4'd12;
    localparam logic [ALUOP_W-1:0] ALU_NOT   = 4'd13;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T4S  = 4'd6,
        S_T5   = 4'd7,
        S_T5M  = 4'd8,
        S_T6M  = 4'd9
    } state_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               is_unary;
        logic               is_hilo;
        logic               illegal;
    } op_info_t;

endpackage
`default_nettype wire

// File: rtl/alu_instr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  alu_instr_sequencer_if
//  Instruction handshake inputs and datapath strobe bundle of the sequencer.
//  Revision: 1.0
// ============================================================================
interface alu_instr_sequencer_if #(
    parameter int NUM_REGS = 16
);
    logic                start;
    logic [31:0]         ir_in;
    logic                mem_ready;

    logic                busy;
    logic                done;
    logic                err;
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;
    logic                PCin;
    logic                PCout;
    logic                MARin;
    logic                MDRin;
    logic                MDRout;
    logic                IRin;
    logic                Yin;
    logic                Zlowin;
    logic                Zhighin;
    logic                Zlowout;
    logic                Zhighout;
    logic                HIin;
    logic                LOin;
    logic                IncPC;
    logic                Read;
    logic [3:0]          ALUop;

    modport master (
        output start, ir_in, mem_ready,
        input  busy, done, err, Rin, Rout, PCin, PCout, MARin, MDRin, MDRout,
               IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
               IncPC, Read, ALUop
    );

    modport slave (
        input  start, ir_in, mem_ready,
        output busy, done, err, Rin, Rout, PCin, PCout, MARin, MDRin, MDRout,
               IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
               IncPC, Read, ALUop
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  alu_op_decode
//  Combinational opcode classifier: ALU select, unary / HI-LO flags, illegal.
//  Revision: 1.0
// ============================================================================
module alu_op_decode
    import cpu_ctrl_pkg::*;
(
    input  wire logic [OPCODE_W-1:0] opcode_i,
    output op_info_t                 info_o
);
    always_comb begin
        info_o = '{alu_op: ALU_PCINC, is_unary: 1'b0, is_hilo: 1'b0, illegal: 1'b0};
        case (opcode_i)
            OP_ADD:  info_o.alu_op = ALU_ADD;
            OP_SUB:  info_o.alu_op = ALU_SUB;
            OP_AND:  info_o.alu_op = ALU_AND;
            OP_OR:   info_o.alu_op = ALU_OR;
            OP_SHR:  info_o.alu_op = ALU_SHR;
            OP_SHRA: info_o.alu_op = ALU_SHRA;
            OP_SHL:  info_o.alu_op = ALU_SHL;
            OP_ROR:  info_o.alu_op = ALU_ROR;
            OP_ROL:  info_o.alu_op = ALU_ROL;
            OP_MUL: begin
                info_o.alu_op  = ALU_MUL;
                info_o.is_hilo = 1'b1;
            end
            OP_DIV: begin
                info_o.alu_op  = ALU_DIV;
                info_o.is_hilo = 1'b1;
            end
            OP_NEG: begin
                info_o.alu_op   = ALU_NEG;
                info_o.is_unary = 1'b1;
            end
            OP_NOT: begin
                info_o.alu_op   = ALU_NOT;
                info_o.is_unary = 1'b1;
            end
            default: info_o.illegal = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  alu_instr_sequencer
//  Hardwired fetch/decode/execute control for register-register ALU ops.
//  Revision: 1.0
// ============================================================================
module alu_instr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int REG_IDX_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  wire logic            clock,
    input  wire logic            clear,
    alu_instr_sequencer_if.slave bus
);
    localparam int               CNT_W       = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_t               state_q;
    logic [CNT_W-1:0]     wait_q;
    logic                 done_q;
    logic                 err_q;

    logic [OPCODE_W-1:0]  opcode;
    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rc;
    op_info_t             info;
    logic [NUM_REGS-1:0]  ra_onehot;
    logic [NUM_REGS-1:0]  rb_onehot;
    logic [NUM_REGS-1:0]  rc_onehot;
    logic                 unused_ir_bits;

    assign opcode         = bus.ir_in[IR_OP_LSB +: OPCODE_W];
    assign ra             = bus.ir_in[IR_RA_LSB +: REG_IDX_W];
    assign rb             = bus.ir_in[IR_RB_LSB +: REG_IDX_W];
    assign rc             = bus.ir_in[IR_RC_LSB +: REG_IDX_W];
    assign unused_ir_bits = ^bus.ir_in[IR_RC_LSB-1:0];

    alu_op_decode u_decode (
        .opcode_i (opcode),
        .info_o   (info)
    );

    // Out-of-range register indices simply match no strobe bit.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_onehot
        assign ra_onehot[gi] = (int'(ra) == gi);
        assign rb_onehot[gi] = (int'(rb) == gi);
        assign rc_onehot[gi] = (int'(rc) == gi);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.start) state_q <= S_T0;
                S_T0: begin
                    state_q <= S_T1;
                    wait_q  <= '0;
                end
                S_T1: begin
                    // Data arriving on the final allowed cycle still wins.
                    if (bus.mem_ready) begin
                        state_q <= S_T2;
                    end else if (wait_q == TIMEOUT_CNT) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q  <= wait_q + CNT_W'(1);
                    end
                end
                S_T2: state_q <= S_T3;
                S_T3: begin
                    if (info.illegal) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                    end else if (info.is_unary) begin
                        state_q <= S_T4S;
                    end else begin
                        state_q <= S_T4;
                    end
                end
                S_T4:  state_q <= info.is_hilo ? S_T5M : S_T5;
                S_T5M: state_q <= S_T6M;
                S_T5, S_T4S, S_T6M: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;

    always_comb begin
        bus.Rin      = '0;
        bus.Rout     = '0;
        bus.PCin     = 1'b0;
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zlowin   = 1'b0;
        bus.Zhighin  = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.ALUop    = ALU_PCINC;
        case (state_q)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (!info.illegal) begin
                    bus.Rout = rb_onehot;
                    if (info.is_unary) begin
                        bus.ALUop  = info.alu_op;
                        bus.Zlowin = 1'b1;
                    end else begin
                        bus.Yin    = 1'b1;
                    end
                end
            end
            S_T4: begin
                bus.Rout    = rc_onehot;
                bus.ALUop   = info.alu_op;
                bus.Zlowin  = 1'b1;
                bus.Zhighin = info.is_hilo;
            end
            S_T5, S_T4S: begin
                bus.Zlowout = 1'b1;
                bus.Rin     = ra_onehot;
            end
            S_T5M: begin
                bus.Zlowout = 1'b1;
                bus.LOin    = 1'b1;
            end
            S_T6M: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_alu_instr_sequencer
//  Drives the sequencer against a bus-level datapath model and checks results.
//  Revision: 1.0
// ============================================================================
module tb_alu_instr_sequencer;
    localparam int NUM_REGS    = 16;
    localparam int REG_IDX_W   = 4;
    localparam int MEM_TIMEOUT = 15;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    alu_instr_sequencer_if #(.NUM_REGS(NUM_REGS)) bus ();

    alu_instr_sequencer #(
        .NUM_REGS    (NUM_REGS),
        .REG_IDX_W   (REG_IDX_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Datapath model owned by the bench
    logic [31:0] R [NUM_REGS];
    logic [31:0] PC, MAR, MDR, IR, Y, HI, LO;
    logic [63:0] Z;
    logic [31:0] instr_word;
    int          wait_n, read_cnt;

    bit s_done, s_err;
    int cnt_busy, cnt_read, cnt_yin, cnt_zhigh, cnt_rin;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction semantics: a = first operand (Rb), b = second (Rc); {HI,LO} result
    function automatic logic [63:0] ref_exec(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            0:  return {32'd0, a + b};
            1:  return {32'd0, a - b};
            2:  return {32'd0, a & b};
            3:  return {32'd0, a | b};
            4:  return {32'd0, a >> s};
            5:  return {32'd0, 32'($signed(a) >>> s)};
            6:  return {32'd0, a << s};
            7:  return {32'd0, (a >> s) | (a << (32 - int'(s)))};
            8:  return {32'd0, (a << s) | (a >> (32 - int'(s)))};
            9:  return 64'(a) * 64'(b);
            10: return (b == 0) ? 64'd0 : {a % b, a / b};
            11: return {32'd0, 32'd0 - a};
            12: return {32'd0, ~a};
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
        return {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'd0};
    endfunction

    function automatic logic [63:0] outs();
        return {13'd0, bus.Rin, bus.Rout, bus.PCin, bus.PCout, bus.MARin, bus.MDRin,
                bus.MDRout, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin, bus.Zlowout,
                bus.Zhighout, bus.HIin, bus.LOin, bus.IncPC, bus.Read, bus.ALUop};
    endfunction

    // One clock: sample strobes mid-cycle, apply them to the model, then cross the edge
    task automatic cycle();
        logic [31:0] dbus;
        logic [63:0] alu;
        int          aop;
        @(negedge clock);
        if (bus.Read) begin
            bus.mem_ready = (read_cnt >= wait_n);
            read_cnt++;
            cnt_read++;
        end else begin
            bus.mem_ready = 1'b0;
        end
        s_done = bus.done;
        s_err  = bus.err;
        check("rout_max_one", 64'($countones(bus.Rout) <= 1), 1);
        check("rin_max_one", 64'($countones(bus.Rin) <= 1), 1);
        check("rin_rout_excl", 64'((|bus.Rin) && (|bus.Rout)), 0);
        if (!bus.busy) check("idle_outputs", outs(), 0);
        if (bus.busy)    cnt_busy++;
        if (bus.Yin)     cnt_yin++;
        if (bus.Zhighin) cnt_zhigh++;
        if (|bus.Rin)    cnt_rin++;

        dbus = 32'd0;
        if (bus.PCout)    dbus = PC;
        if (bus.Zlowout)  dbus = Z[31:0];
        if (bus.Zhighout) dbus = Z[63:32];
        if (bus.MDRout)   dbus = MDR;
        for (int i = 0; i < NUM_REGS; i++) if (bus.Rout[i]) dbus = R[i];
        aop = int'(bus.ALUop);
        if (aop == 0)                 alu = {32'd0, dbus + 32'd1};
        else if (aop == 12 || aop == 13) alu = ref_exec(aop - 1, dbus, 32'd0);
        else                          alu = ref_exec(aop - 1, Y, dbus);

        if (bus.MARin)   MAR = dbus;
        if (bus.Zlowin)  Z[31:0] = alu[31:0];
        if (bus.Zhighin) Z[63:32] = alu[63:32];
        if (bus.PCin)    PC = dbus;
        if (bus.MDRin && bus.Read && bus.mem_ready) MDR = instr_word;
        else if (bus.MDRin && !bus.Read)            MDR = dbus;
        if (bus.IRin)    IR = dbus;
        if (bus.Yin)     Y = dbus;
        if (bus.LOin)    LO = dbus;
        if (bus.HIin)    HI = dbus;
        for (int i = 0; i < NUM_REGS; i++) if (bus.Rin[i]) R[i] = dbus;
        @(posedge clock);
        #1;
        bus.ir_in = IR;
    endtask

    task automatic begin_instr(input logic [31:0] instr, input int wait_cycles);
        instr_word = instr;
        wait_n     = wait_cycles;
        read_cnt   = 0;
        cnt_busy   = 0;
        cnt_read   = 0;
        cnt_yin    = 0;
        cnt_zhigh  = 0;
        cnt_rin    = 0;
    endtask

    task automatic exec_and_check(input string tag, input logic [31:0] instr, input int wait_cycles);
        logic [31:0] snap [NUM_REGS];
        logic [31:0] snap_hi, snap_lo, snap_pc, exp_r;
        logic [63:0] res;
        int  op, ra, rb, rc, exp_lat, lat, diffs;
        bit  illegal, timeout, unary, hilo, fail, got_done, got_err;
        op      = int'(instr[31:27]);
        ra      = int'(instr[26:23]);
        rb      = int'(instr[22:19]);
        rc      = int'(instr[18:15]);
        illegal = (op > 12);
        timeout = (wait_cycles > MEM_TIMEOUT);
        fail    = illegal || timeout;
        unary   = (op == 11 || op == 12);
        hilo    = (op == 9 || op == 10);
        snap    = R;
        snap_hi = HI;
        snap_lo = LO;
        snap_pc = PC;
        res     = ref_exec(op, R[rb], R[rc]);
        if (timeout)      exp_lat = MEM_TIMEOUT + 3;
        else if (illegal) exp_lat = 5 + wait_cycles;
        else if (unary)   exp_lat = 6 + wait_cycles;
        else if (hilo)    exp_lat = 8 + wait_cycles;
        else              exp_lat = 7 + wait_cycles;

        begin_instr(instr, wait_cycles);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        check({tag, "_prev_pulse_clear"}, {62'd0, s_done, s_err}, 0);
        lat = -1;
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            cycle();
            if (s_done || s_err) begin
                lat      = n;
                got_done = s_done;
                got_err  = s_err;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_done_err"}, {62'd0, got_done, got_err}, {62'd0, !fail, fail});
        check({tag, "_busy_cycles"}, 64'(cnt_busy), 64'(exp_lat - 1));
        check({tag, "_read_cycles"}, 64'(cnt_read), 64'(timeout ? MEM_TIMEOUT + 1 : wait_cycles + 1));
        check({tag, "_pc"}, PC, snap_pc + 32'd1);
        if (!fail) begin
            check({tag, "_yin_cycles"}, 64'(cnt_yin), unary ? 0 : 1);
            check({tag, "_zhighin_cycles"}, 64'(cnt_zhigh), hilo ? 1 : 0);
        end
        check({tag, "_rin_cycles"}, 64'(cnt_rin), (fail || hilo) ? 0 : 1);
        check({tag, "_hi"}, HI, (!fail && hilo) ? res[63:32] : snap_hi);
        check({tag, "_lo"}, LO, (!fail && hilo) ? res[31:0] : snap_lo);
        diffs = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_r = (!fail && !hilo && i == ra) ? res[31:0] : snap[i];
            if (R[i] !== exp_r) diffs++;
        end
        check({tag, "_regfile"}, 64'(diffs), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] instr;
        int          r, w, op;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir_in     = 32'd0;
        PC = 32'd0; MAR = 32'd0; MDR = 32'd0; IR = 32'd0;
        Y  = 32'd0; HI = 32'd0;  LO = 32'd0;  Z = 64'd0;
        for (int i = 0; i < NUM_REGS; i++) R[i] = $urandom;

        clear = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        clear = 1'b0;
        check("reset_busy", 64'(bus.busy), 0);
        check("reset_done_err", {62'd0, bus.done, bus.err}, 0);
        check("reset_outputs", outs(), 0);

        R[0] = 32'h09; R[4] = 32'h02;
        exec_and_check("rol", 32'h4382_0000, 0);
        check("rol_r7", R[7], 32'h24);

        R[2] = 32'd6; R[3] = 32'd7;
        exec_and_check("mul", mk(9, 1, 2, 3), 0);
        check("mul_lo", LO, 32'd42);
        check("mul_hi", HI, 32'd0);

        R[1] = 32'd5;
        exec_and_check("neg", mk(11, 6, 1, 0), 0);
        check("neg_r6", R[6], 32'hFFFF_FFFB);

        exec_and_check("add_wait3", mk(0, 5, 2, 3), 3);
        check("add_wait3_r5", R[5], 32'd13);
        exec_and_check("div_same_regs", mk(10, 3, 3, 3), 0);
        exec_and_check("timeout_edge", mk(1, 9, 4, 0), MEM_TIMEOUT);
        exec_and_check("timeout", mk(2, 9, 4, 0), MEM_TIMEOUT + 1);
        exec_and_check("illegal20", mk(20, 7, 1, 2), 0);

        // Abort an instruction in T4, then run ADD 3+4
        R[8] = 32'd3; R[9] = 32'd4;
        begin_instr(mk(0, 10, 8, 9), 0);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        repeat (4) cycle();
        check("clr_in_t4", {61'd0, bus.Zlowin, bus.Yin, |bus.Rout}, 64'b101);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check("clr_busy", 64'(bus.busy), 0);
        check("clr_outputs", outs(), 0);
        cycle();
        exec_and_check("add_after_clear", mk(0, 10, 8, 9), 0);
        check("add_after_clear_r10", R[10], 32'd7);

        for (int k = 0; k < 40; k++) begin
            R[$urandom_range(0, NUM_REGS - 1)] = $urandom;
            R[$urandom_range(0, NUM_REGS - 1)] = $urandom_range(0, 40);
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 31)) : int'($urandom_range(0, 12));
            r  = int'($urandom_range(0, 11));
            w  = (r == 11) ? MEM_TIMEOUT + 1 : (r == 10) ? MEM_TIMEOUT : int'($urandom_range(0, 3));
            instr = mk(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            exec_and_check($sformatf("rand%0d_op%0d", k, op), instr, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
